capture_period_fifo: RTL and testbench
======================================

// Module: capture_period_fifo
// PURPOSE
//  Downstream consumer of the input-capture stage. Watches the capture interrupt flag and
//  samples the captured counter value. Returns the flag-clear handshake to the capture stage.
//  Computes the modular period between successive captures and buffers the periods in a
//  small FIFO. Software/DMA drains the FIFO over a valid/ready interface.
// PARAMETERS
//  CW           4  width of captured counter value and of period results
//  DEPTH        4  FIFO entries (power of two, >=2)
//  SYNC_STAGES  2  flip-flop stages synchronising cap_flag into clk domain (>=2)
// PORTS
//  clk        in   1                   system clock, all logic on posedge
//  rstVal     in   1                   reset, asynchronous, active-high
//  enable     in   1                   1 = accept new captures; 0 = hold in IDLE
//  cap_val    in   CW                  captured counter value from capture stage
//  cap_flag   in   1                   capture interrupt flag (level, async to clk)
//  cap_clr    out  1                   flag-clear request to capture stage (level)
//  per_data   out  CW                  FIFO head: period = cur - prev mod 2^CW
//  per_valid  out  1                   FIFO non-empty
//  per_ready  in   1                   consumer pop; pop when per_valid & per_ready
//  level      out  $clog2(DEPTH+1)     current FIFO occupancy
//  ovf        out  1                   sticky: period dropped because FIFO was full
//  ovf_clr    in   1                   synchronous clear of ovf
// BEHAVIOUR
//  Reset (rstVal=1, async): cap_clr=0, per_valid=0, per_data=0, level=0, ovf=0.
//   Also clears have_prev=0, prev=0, FSM=IDLE and FIFO pointers. Reset mid-handshake
//   drops cap_clr immediately; the capture stage flag stays set and is re-processed after reset.
//  Sync: flag_s = cap_flag delayed SYNC_STAGES clk cycles. The sync flops are reset to 0.
//  FSM (one-hot or binary, 3 states):
//   IDLE:   if enable & flag_s -> SAMPLE; else stay.
//   SAMPLE: one cycle. Registers cur=cap_val.
//           if have_prev, pushes (cap_val - prev) mod 2^CW; else no push.
//           Then prev<=cap_val and have_prev<=1 -> CLEAR.
//   CLEAR:  cap_clr=1 (registered, asserted on entry).
//           When flag_s==0 -> IDLE; cap_clr is 0 from the IDLE cycle on.
//  Latency: cap_flag rise -> SAMPLE is SYNC_STAGES+1 clk. Push visible on per_valid the
//   cycle after SAMPLE.
//  Arithmetic: unsigned CW-bit subtraction. Wrap-around is implicit: prev=14, cur=2 gives 4.
//   cur==prev gives 0, which is pushed as a full 2^CW counter period.
//  First capture after reset (or after rstVal) only seeds prev; it produces no output.
//  enable=0 during SAMPLE/CLEAR: the current handshake completes, then the FSM stays in IDLE.
//  FIFO: per_data is the head entry (show-ahead).
//   Push when full with no pop in the same cycle: entry dropped, ovf<=1, prev still updated.
//   Push when full with a simultaneous pop: both happen, level unchanged, no ovf.
//   Pop when empty: ignored.
//   ovf_clr and a new overflow in the same cycle: ovf stays 1 (set wins).
//  per_data is undefined-free: it holds the last value (0 after reset) when empty.
// STRUCTURE
//  Shared package cap_pkg: CW default, FSM state typedef (IDLE/SAMPLE/CLEAR), level width fn.
//  One sub-module: cap_sync_fifo (DEPTH x CW, show-ahead, push/pop/full/empty/level).
//  Synchroniser, FSM and period arithmetic live in the top module.
// TESTING
//  1 Reset, then captures at cap_val=3 then 7 (flag pulses with handshake) -> no output, then per_data=4, level=1.
//  2 Wrap: prev=14, cap_val=2 -> per_data=4; cap_val equal to prev -> per_data=0 pushed.
//  3 Handshake: hold cap_flag=1 after cap_clr rises -> FSM stays CLEAR, cap_clr=1; drop flag -> cap_clr=0 after SYNC_STAGES+1 cycles.
//  4 Fill: per_ready=0, DEPTH+1 periods -> level=DEPTH, ovf=1, head unchanged; ovf_clr -> ovf=0.
//  5 Full with per_ready=1 during push -> level stays DEPTH, ovf stays 0, ordering preserved.
//  6 Assert rstVal while in CLEAR -> cap_clr=0 immediately; next capture only seeds prev (no output).

Source files
------------

// File: rtl/cap_pkg.sv
// Shared types and helpers for the capture-period consumer.
package cap_pkg;

    localparam int CW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CLEAR  = 2'd2
    } cap_st_e;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/cap_sync_fifo.sv
// Show-ahead synchronous FIFO; push while full is accepted only alongside a pop.
module cap_sync_fifo
    import cap_pkg::*;
#(
    parameter int CW    = CW_DEF,
    parameter int DEPTH = 4,
    localparam int LW   = lvl_w(DEPTH),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstVal,
    input  logic          i_push,
    input  logic [CW-1:0] i_din,
    input  logic          i_pop,
    output logic [CW-1:0] o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);

    logic [CW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr, r_rptr;
    logic [CW-1:0] r_last;
    logic [LW-1:0] w_level;
    logic          w_do_push, w_do_pop;

    assign w_level   = LW'(r_wptr - r_rptr);
    assign o_level   = w_level;
    assign o_full    = (w_level == LW'(DEPTH));
    assign o_empty   = (w_level == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // When empty, keep presenting the last entry that left so the output never floats.
    assign o_dout = o_empty ? r_last : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    always_ff @(posedge clk or posedge rstVal) begin
        if (rstVal) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_last <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_last <= r_mem[r_rptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/capture_period_fifo.sv
// Capture-flag handshake, period between successive captures, and a period FIFO.
module capture_period_fifo
    import cap_pkg::*;
#(
    parameter int CW          = CW_DEF,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rstVal,
    input  logic                    enable,
    input  logic [CW-1:0]           cap_val,
    input  logic                    cap_flag,
    output logic                    cap_clr,
    output logic [CW-1:0]           per_data,
    output logic                    per_valid,
    input  logic                    per_ready,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic                    ovf,
    input  logic                    ovf_clr
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_flag_s;
    cap_st_e                r_state, w_next;
    logic                   r_have_prev;
    logic [CW-1:0]          r_prev;
    logic                   r_cap_clr;
    logic                   r_ovf;
    logic                   w_sample, w_push_req, w_drop;
    logic [CW-1:0]          w_period;
    logic                   w_full, w_empty;

    always_ff @(posedge clk or posedge rstVal) begin
        if (rstVal) r_sync <= '0;
        else        r_sync <= {r_sync[SYNC_STAGES-2:0], cap_flag};
    end
    assign w_flag_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rstVal) begin
        if (rstVal) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (enable && w_flag_s) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = ST_CLEAR;
            ST_CLEAR:  if (!w_flag_s) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Zero difference is a full counter wrap and is still a valid period.
    always_comb begin
        w_sample   = (r_state == ST_SAMPLE);
        w_push_req = w_sample & r_have_prev;
        w_period   = cap_val - r_prev;
        w_drop     = w_push_req & w_full & ~per_ready;
    end

    always_ff @(posedge clk or posedge rstVal) begin
        if (rstVal) begin
            r_cap_clr   <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev      <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_cap_clr <= (w_next == ST_CLEAR);
            if (w_sample) begin
                r_prev      <= cap_val;
                r_have_prev <= 1'b1;
            end
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    cap_sync_fifo #(
        .CW    (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstVal  (rstVal),
        .i_push  (w_push_req),
        .i_din   (w_period),
        .i_pop   (per_ready),
        .o_dout  (per_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    assign cap_clr   = r_cap_clr;
    assign per_valid = ~w_empty;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_capture_period_fifo.sv
// Randomised bench for capture_period_fifo against a queue-based period model.
module tb_capture_period_fifo;
    import cap_pkg::*;

    localparam int CW    = 4;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int MASK  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstVal, enable, cap_flag, per_ready, ovf_clr;
    logic [CW-1:0] cap_val;
    logic          cap_clr, per_valid, ovf;
    logic [CW-1:0] per_data;
    logic [2:0]    level;

    int n_chk = 0;
    int n_bad = 0;

    int q[$];
    bit have_prev;
    int prev;
    bit m_ovf;
    int last_pop;

    capture_period_fifo #(.CW(CW), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk       (clk),
        .rstVal    (rstVal),
        .enable    (enable),
        .cap_val   (cap_val),
        .cap_flag  (cap_flag),
        .cap_clr   (cap_clr),
        .per_data  (per_data),
        .per_valid (per_valid),
        .per_ready (per_ready),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        have_prev = 0;
        prev      = 0;
        m_ovf     = 0;
        last_pop  = 0;
    endtask

    // One capture as seen by the consumer; pop means a pop lands in the push cycle.
    task automatic model_cap(input int v, input bit pop);
        bit popped, drop;
        popped = pop && (q.size() > 0);
        drop   = have_prev && (q.size() == DEPTH) && !popped;
        if (popped) last_pop = q.pop_front();
        if (have_prev) begin
            if (drop) m_ovf = 1;
            else      q.push_back((v - prev) & MASK);
        end
        prev      = v;
        have_prev = 1;
    endtask

    task automatic check_all();
        chk("level", level, q.size());
        chk("valid", per_valid, q.size() > 0);
        chk("data", per_data, (q.size() > 0) ? q[0] : last_pop);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic wait_clr(input logic lvl, output int cnt);
        cnt = 0;
        while (cap_clr !== lvl && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("wait_clr", cap_clr, lvl);
    endtask

    // Entered at a negedge with cap_flag low and the FSM idle.
    task automatic capture(input int v, input bit pop, input bit hold);
        int cnt;
        cap_val  = CW'(v);
        cap_flag = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        chk("clr_pre", cap_clr, 0);
        per_ready = pop;
        @(negedge clk);
        per_ready = 1'b0;
        chk("clr_rise", cap_clr, 1);
        model_cap(v, pop);
        check_all();
        if (hold) begin
            repeat (6) @(negedge clk);
            chk("clr_hold", cap_clr, 1);
        end
        cap_flag = 1'b0;
        wait_clr(1'b0, cnt);
        chk("clr_fall_lat", cnt, SYNC + 1);
    endtask

    task automatic pop_one();
        per_ready = 1'b1;
        @(negedge clk);
        per_ready = 1'b0;
        if (q.size() > 0) last_pop = q.pop_front();
        check_all();
    endtask

    task automatic clear_ovf();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        m_ovf   = 0;
        check_all();
    endtask

    initial begin
        int cnt, v;
        rstVal = 1'b1; enable = 1'b1; cap_flag = 1'b0; per_ready = 1'b0;
        ovf_clr = 1'b0; cap_val = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_clr", cap_clr, 0);
        check_all();
        rstVal = 1'b0;
        @(negedge clk);

        // first capture only seeds, second yields 7-3
        capture(3, 0, 0);
        check_all();
        capture(7, 0, 0);
        chk("t1_data", per_data, 4);
        chk("t1_level", level, 1);

        // wrap-around and equal values
        capture(14, 0, 0);
        capture(2, 0, 0);
        chk("t2_wrap", per_data, 4'd4);
        capture(2, 0, 0);
        while (q.size() > 1) pop_one();
        chk("t2_zero", per_data, 0);
        pop_one();

        // flag held after cap_clr keeps the FSM in CLEAR
        capture(5, 0, 1);

        // enable low holds the FSM idle even with the flag up
        enable   = 1'b0;
        cap_val  = CW'(9);
        cap_flag = 1'b1;
        repeat (8) @(negedge clk);
        chk("en_hold", cap_clr, 0);
        check_all();
        enable = 1'b1;
        wait_clr(1'b1, cnt);
        model_cap(9, 0);
        check_all();
        cap_flag = 1'b0;
        wait_clr(1'b0, cnt);

        // fill past depth with no consumer
        while (q.size() > 0) pop_one();
        for (int i = 0; i < DEPTH + 1; i++) capture($urandom_range(0, MASK), 0, 0);
        chk("t4_level", level, DEPTH);
        chk("t4_ovf", ovf, 1);
        clear_ovf();

        // full with a pop in the push cycle: no loss, order kept
        for (int i = 0; i < 3; i++) capture($urandom_range(0, MASK), 1, 0);
        chk("t5_level", level, DEPTH);
        chk("t5_ovf", ovf, 0);
        while (q.size() > 0) pop_one();

        // reset while in CLEAR
        cap_val  = CW'(11);
        cap_flag = 1'b1;
        wait_clr(1'b1, cnt);
        rstVal = 1'b1;
        #1;
        chk("t6_async_clr", cap_clr, 0);
        model_reset();
        @(negedge clk);
        rstVal = 1'b0;
        check_all();
        wait_clr(1'b1, cnt);
        model_cap(11, 0);
        check_all();
        chk("t6_seed_only", level, 0);
        cap_flag = 1'b0;
        wait_clr(1'b0, cnt);
        capture(13, 0, 0);
        chk("t6_after", per_data, 2);

        // randomised mix of captures, pops and ovf clears
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, MASK);
            capture(v, $urandom_range(0, 3) == 0, 0);
            if ($urandom_range(0, 2) == 0) pop_one();
            if ($urandom_range(0, 5) == 0) clear_ovf();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1);
    end

endmodule
